// File: rtl/sd_read_sector.sv
// Single-sector SPI read engine: issues CMD17, waits for R1 and the 0xFE token,
// then streams the 512-byte block out as 256 16-bit words.
module sd_read_sector #(
    parameter int DIV_FREQ      = 4,
    parameter int R1_TIMEOUT    = 64,
    parameter int TOKEN_TIMEOUT = 50000
) (
    input  logic        clk_ref,
    input  logic        rst,
    input  logic        sd_init_done,
    input  logic        rd_start,
    input  logic [31:0] rd_sec_addr,
    input  logic        sd_miso,
    output logic        sd_clk,
    output logic        sd_cs,
    output logic        sd_mosi,
    output logic        rd_busy,
    output logic        rd_val_en,
    output logic [15:0] rd_val_data,
    output logic        rd_done,
    output logic        rd_err
);
    localparam int HALF  = DIV_FREQ / 2;
    localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);
    localparam logic [15:0]      R1_LAST  = 16'(R1_TIMEOUT - 1);
    localparam logic [15:0]      TOK_LAST = 16'(TOKEN_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, SEND_CMD, WAIT_R1, R1_CAP, WAIT_TOKEN, DATA, CRC, ERR, TRAIL
    } state_t;

    state_t           state_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic             sd_clk_q, sd_cs_q, sd_mosi_q;
    logic             busy_q, val_en_q, done_q, err_q;
    logic [15:0]      val_data_q;
    logic [47:0]      cmd_q;
    logic [5:0]       bit_cnt_q;
    logic [7:0]       shift8_q;
    logic [15:0]      data_q;
    logic [7:0]       word_cnt_q;
    logic [15:0]      tmo_q;

    logic             tick, rise_tick, fall_tick;
    logic [7:0]       shift8_d;
    logic [15:0]      data_d;

    assign tick      = (div_cnt_q == DIV_LAST);
    assign rise_tick = tick && !sd_clk_q;
    assign fall_tick = tick && sd_clk_q;
    assign shift8_d  = {shift8_q[6:0], sd_miso};
    assign data_d    = {data_q[14:0], sd_miso};

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            sd_clk_q   <= 1'b0;
            sd_cs_q    <= 1'b1;
            sd_mosi_q  <= 1'b1;
            busy_q     <= 1'b0;
            val_en_q   <= 1'b0;
            val_data_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cmd_q      <= '0;
            bit_cnt_q  <= '0;
            shift8_q   <= 8'hFF;
            data_q     <= '0;
            word_cnt_q <= '0;
            tmo_q      <= '0;
        end else begin
            // NOTE: strobes default low every cycle so only the firing branch raises them.
            val_en_q  <= 1'b0;
            done_q    <= 1'b0;
            div_cnt_q <= tick ? '0 : div_cnt_q + DIV_W'(1);
            if (tick)
                sd_clk_q <= !sd_clk_q;
            if (fall_tick && state_q != SEND_CMD)
                sd_mosi_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (rd_start && sd_init_done && !busy_q) begin
                        cmd_q     <= {8'h51, rd_sec_addr, 8'hFF};
                        err_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        bit_cnt_q <= '0;
                        state_q   <= SEND_CMD;
                    end
                end
                SEND_CMD: begin
                    if (fall_tick) begin
                        sd_cs_q   <= 1'b0;
                        sd_mosi_q <= cmd_q[47];
                        cmd_q     <= {cmd_q[46:0], 1'b1};
                        bit_cnt_q <= bit_cnt_q + 6'd1;
                        if (bit_cnt_q == 6'd47) begin
                            tmo_q   <= '0;
                            state_q <= WAIT_R1;
                        end
                    end
                end
                WAIT_R1: begin
                    if (rise_tick) begin
                        if (!sd_miso) begin
                            shift8_q  <= shift8_d;
                            bit_cnt_q <= 6'd1;
                            state_q   <= R1_CAP;
                        end else if (tmo_q == R1_LAST) begin
                            state_q <= ERR;
                        end else begin
                            tmo_q <= tmo_q + 16'd1;
                        end
                    end
                end
                R1_CAP: begin
                    if (rise_tick) begin
                        shift8_q  <= shift8_d;
                        bit_cnt_q <= bit_cnt_q + 6'd1;
                        if (bit_cnt_q == 6'd7) begin
                            // The token window starts fresh from all-ones.
                            shift8_q <= 8'hFF;
                            tmo_q    <= '0;
                            state_q  <= (shift8_d == 8'h00) ? WAIT_TOKEN : ERR;
                        end
                    end
                end
                WAIT_TOKEN: begin
                    if (rise_tick) begin
                        shift8_q <= shift8_d;
                        if (shift8_d == 8'hFE) begin
                            bit_cnt_q  <= '0;
                            word_cnt_q <= '0;
                            state_q    <= DATA;
                        end else if (tmo_q == TOK_LAST) begin
                            state_q <= ERR;
                        end else begin
                            tmo_q <= tmo_q + 16'd1;
                        end
                    end
                end
                DATA: begin
                    if (rise_tick) begin
                        data_q    <= data_d;
                        bit_cnt_q <= bit_cnt_q + 6'd1;
                        if (bit_cnt_q == 6'd15) begin
                            bit_cnt_q  <= '0;
                            val_data_q <= data_d;
                            val_en_q   <= 1'b1;
                            word_cnt_q <= word_cnt_q + 8'd1;
                            if (word_cnt_q == 8'hFF)
                                state_q <= CRC;
                        end
                    end
                end
                CRC: begin
                    if (rise_tick) begin
                        bit_cnt_q <= bit_cnt_q + 6'd1;
                        if (bit_cnt_q == 6'd15) begin
                            bit_cnt_q <= '0;
                            state_q   <= TRAIL;
                        end
                    end
                end
                ERR: begin
                    err_q     <= 1'b1;
                    bit_cnt_q <= '0;
                    state_q   <= TRAIL;
                end
                TRAIL: begin
                    // First fall_tick releases CS, then eight idle clocks follow.
                    if (fall_tick) begin
                        sd_cs_q <= 1'b1;
                        if (bit_cnt_q == 6'd8) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 6'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sd_clk      = sd_clk_q;
    assign sd_cs       = sd_cs_q;
    assign sd_mosi     = sd_mosi_q;
    assign rd_busy     = busy_q;
    assign rd_val_en   = val_en_q;
    assign rd_val_data = val_data_q;
    assign rd_done     = done_q;
    assign rd_err      = err_q;
endmodule
